// File: rtl/fxp_mul.sv
// rtl/fxp_mul.sv - two-stage pipelined signed fixed-point multiplier; define MUL_SAT_EN to saturate prod on overflow
module fxp_mul #(
    parameter int DATA_WIDTH = 32,
    parameter int BIN_POS    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] lhs,
    input  logic [DATA_WIDTH-1:0] rhs,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] prod,
    output logic                  ovf
);

    localparam int PW = 2 * DATA_WIDTH;

    logic [DATA_WIDTH-1:0] lhs_r;
    logic [DATA_WIDTH-1:0] rhs_r;
    logic                  valid_r;

    logic signed [PW-1:0]  lhs_x;
    logic signed [PW-1:0]  rhs_x;
    logic signed [PW-1:0]  p_full;
    logic signed [PW-1:0]  s_full;
    logic [DATA_WIDTH:0]   s_hi;
    logic                  ovf_c;
    logic [DATA_WIDTH-1:0] prod_c;

    // Operands are sign-extended to the full product width so the multiply
    // is a plain same-width signed product with no context surprises.
    assign lhs_x  = $signed({{DATA_WIDTH{lhs_r[DATA_WIDTH-1]}}, lhs_r});
    assign rhs_x  = $signed({{DATA_WIDTH{rhs_r[DATA_WIDTH-1]}}, rhs_r});
    assign p_full = lhs_x * rhs_x;

    // Arithmetic shift drops fractional bits, rounding toward -infinity.
    assign s_full = p_full >>> BIN_POS;

    // The scaled value fits in DATA_WIDTH signed bits only when every bit
    // from the result sign bit upward is a copy of the same value.
    assign s_hi  = s_full[PW-1:DATA_WIDTH-1];
    assign ovf_c = !((&s_hi) || !(|s_hi));

`ifdef MUL_SAT_EN
    // Clamp to the representable extreme on the side of the true sign.
    always_comb begin
        prod_c = s_full[DATA_WIDTH-1:0];
        if (ovf_c) begin
            if (s_full[PW-1])
                prod_c = {1'b1, {(DATA_WIDTH-1){1'b0}}};
            else
                prod_c = {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end
    end
`else
    // Wrap-around: keep the low DATA_WIDTH bits of the scaled product.
    assign prod_c = s_full[DATA_WIDTH-1:0];
`endif

    // Stage 1: capture operands on valid input; valid bit tracks in_valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lhs_r   <= '0;
            rhs_r   <= '0;
            valid_r <= 1'b0;
        end else begin
            valid_r <= in_valid;
            if (in_valid) begin
                lhs_r <= lhs;
                rhs_r <= rhs;
            end
        end
    end

    // Stage 2: register the result; prod/ovf hold when no result arrives.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            prod      <= '0;
            ovf       <= 1'b0;
        end else begin
            out_valid <= valid_r;
            if (valid_r) begin
                prod <= prod_c;
                ovf  <= ovf_c;
            end
        end
    end

endmodule

// File: tb/tb_fxp_mul.sv
// tb/tb_fxp_mul.sv - directed self-checking bench for fxp_mul in Q8.8
module tb_fxp_mul;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [15:0] lhs;
    logic [15:0] rhs;
    logic        out_valid;
    logic [15:0] prod;
    logic        ovf;

    int errors = 0;
    int checks = 0;

`ifdef MUL_SAT_EN
    localparam logic [15:0] EXP_POS_OVF  = 16'h7FFF;
    localparam logic [15:0] EXP_MIN_MIN  = 16'h7FFF;
`else
    localparam logic [15:0] EXP_POS_OVF  = 16'hFF00;
    localparam logic [15:0] EXP_MIN_MIN  = 16'h0000;
`endif

    fxp_mul #(
        .DATA_WIDTH (16),
        .BIN_POS    (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .lhs       (lhs),
        .rhs       (rhs),
        .out_valid (out_valid),
        .prod      (prod),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // advance one rising edge, then settle away from it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // present one pair for one cycle, then idle one cycle; ends just after the result edge
    task automatic single(input logic [15:0] a, input logic [15:0] b, input string tag);
        lhs = a;
        rhs = b;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        lhs = 16'hDEAD;
        rhs = 16'hBEEF;
        chk({tag, "_early_valid"}, {31'd0, out_valid}, 32'd0);
        step();
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    endtask

    initial begin
        rst = 1'b0;
        in_valid = 1'b0;
        lhs = 16'h0;
        rhs = 16'h0;
        step();
        step();
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_prod", {16'd0, prod}, 32'd0);
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
        rst = 1'b1;
        step();

        // basic
        single(16'h0180, 16'h0200, "basic");
        chk("basic_prod", {16'd0, prod}, 32'h0300);
        chk("basic_ovf", {31'd0, ovf}, 32'd0);
        step();
        chk("basic_pulse", {31'd0, out_valid}, 32'd0);
        chk("basic_hold", {16'd0, prod}, 32'h0300);

        // signed with truncation
        single(16'hFF00, 16'h0080, "neg_half");
        chk("neg_half_prod", {16'd0, prod}, 32'hFF80);
        chk("neg_half_ovf", {31'd0, ovf}, 32'd0);

        single(16'hFFFF, 16'h0001, "neg_lsb");
        chk("neg_lsb_prod", {16'd0, prod}, 32'hFFFF);
        chk("neg_lsb_ovf", {31'd0, ovf}, 32'd0);

        // overflow cases
        single(16'h7FFF, 16'h7FFF, "pos_ovf");
        chk("pos_ovf_prod", {16'd0, prod}, {16'd0, EXP_POS_OVF});
        chk("pos_ovf_ovf", {31'd0, ovf}, 32'd1);

        single(16'h8000, 16'h8000, "min_min");
        chk("min_min_prod", {16'd0, prod}, {16'd0, EXP_MIN_MIN});
        chk("min_min_ovf", {31'd0, ovf}, 32'd1);

        // zero operand clears ovf
        single(16'h0000, 16'h7FFF, "zero");
        chk("zero_prod", {16'd0, prod}, 32'h0000);
        chk("zero_ovf", {31'd0, ovf}, 32'd0);
        step();

        // streaming four back-to-back pairs
        in_valid = 1'b1;
        lhs = 16'h0100; rhs = 16'h0100; step();
        chk("strm_lat0", {31'd0, out_valid}, 32'd0);
        lhs = 16'h0200; rhs = 16'h0300; step();
        chk("strm_v0", {31'd0, out_valid}, 32'd1);
        chk("strm_p0", {16'd0, prod}, 32'h0100);
        lhs = 16'hFE00; rhs = 16'h0400; step();
        chk("strm_v1", {31'd0, out_valid}, 32'd1);
        chk("strm_p1", {16'd0, prod}, 32'h0600);
        lhs = 16'h0000; rhs = 16'h0500; step();
        chk("strm_v2", {31'd0, out_valid}, 32'd1);
        chk("strm_p2", {16'd0, prod}, 32'hF800);
        in_valid = 1'b0; step();
        chk("strm_v3", {31'd0, out_valid}, 32'd1);
        chk("strm_p3", {16'd0, prod}, 32'h0000);
        step();
        chk("strm_end", {31'd0, out_valid}, 32'd0);

        // reset mid-cycle with two pairs in flight
        in_valid = 1'b1;
        lhs = 16'h7FFF; rhs = 16'h7FFF; step();
        lhs = 16'h0180; rhs = 16'h0200; step();
        in_valid = 1'b0;
        chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        chk("pre_rst_prod", {16'd0, prod}, {16'd0, EXP_POS_OVF});
        chk("pre_rst_ovf", {31'd0, ovf}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("async_rst_prod", {16'd0, prod}, 32'd0);
        chk("async_rst_ovf", {31'd0, ovf}, 32'd0);
        step();
        step();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post_rst_idle", {31'd0, out_valid}, 32'd0);
        end
        single(16'hFF00, 16'h0080, "post_rst");
        chk("post_rst_prod", {16'd0, prod}, 32'hFF80);
        chk("post_rst_ovf", {31'd0, ovf}, 32'd0);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fxp_mul.md
Name: fxp_mul

Overview:
- Pipelined signed fixed-point multiplier.
- Computes lhs*rhs in two's-complement Q format with BIN_POS fractional bits and returns a DATA_WIDTH result.
- Used as the arithmetic primitive inside the matrix blocks, e.g. determinant and product units.
- Fully pipelined: accepts one operand pair per clock, no backpressure.

Parameters:
- DATA_WIDTH, 32, width of each operand and of the result in bits; must be at least 2.
- BIN_POS, 16, number of fractional bits (binary point position); must satisfy 0 <= BIN_POS < DATA_WIDTH.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-low reset. rst=0 clears all state immediately; release is taken on a clk edge.
- in_valid  input  1  lhs/rhs carry a new operand pair this cycle.
- lhs  input  DATA_WIDTH  signed fixed-point multiplicand.
- rhs  input  DATA_WIDTH  signed fixed-point multiplier.
- out_valid  output  1  prod/ovf hold the result of a pair accepted 2 cycles earlier.
- prod  output  DATA_WIDTH  signed fixed-point product.
- ovf  output  1  the scaled product did not fit in DATA_WIDTH signed bits.

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous and active-low.
- Reset (rst=0): all registers clear asynchronously; out_valid=0, prod=0, ovf=0.
- Stage 1: when in_valid=1, register lhs and rhs; the stage-1 valid bit follows in_valid every cycle. When in_valid=0, the operand registers hold their value.
- Stage 2 arithmetic:
  - P = signed(lhs_r) * signed(rhs_r), full 2*DATA_WIDTH bits.
  - S = P arithmetically shifted right by BIN_POS (truncation toward -infinity, no rounding).
- Overflow: ovf_c = 1 when S lies outside [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]. Check: bits S[2*DATA_WIDTH-1 : DATA_WIDTH-1] are not all equal.
- Stage 2 register: when stage-1 valid=1, prod <= result and ovf <= ovf_c. out_valid <= stage-1 valid every cycle.
- When no result is produced, prod and ovf hold their last value.
- Latency: exactly 2 clk edges from in_valid sample to out_valid=1. Throughput: 1 per cycle, so back-to-back inputs give back-to-back outputs in order.
- No stall or backpressure; results are presented for one cycle only.
- Reset mid-operation: in-flight pairs are discarded. The first valid after reset release comes 2 cycles after the first in_valid sampled post-reset.
- Boundaries:
  - Any operand 0 gives prod=0, ovf=0.
  - Most-negative times most-negative always overflows.
  - Negative products truncate toward -infinity, e.g. the smallest negative magnitude stays -1 LSB.

Optional Feature:
- Macro: MUL_SAT_EN.
- Defined: on overflow, prod saturates to 2^(DATA_WIDTH-1)-1 when S>0, or to -2^(DATA_WIDTH-1) when S<0.
- Not defined: prod = S[DATA_WIDTH-1:0], wrap-around.
- ovf is reported identically in both builds. Latency and handshake are unchanged.

Test Plan:
All cases use DATA_WIDTH=16, BIN_POS=8.
- Basic: lhs=0x0180 (1.5), rhs=0x0200 (2.0), in_valid pulse -> 2 cycles later out_valid=1, prod=0x0300, ovf=0.
- Signed and truncation:
  - 0xFF00 (-1.0) * 0x0080 (0.5) -> prod=0xFF80.
  - 0xFFFF * 0x0001 -> prod=0xFFFF, ovf=0.
- Overflow, positive: 0x7FFF * 0x7FFF -> ovf=1; prod=0xFF00 without MUL_SAT_EN, 0x7FFF with it.
- Overflow, corner: 0x8000 * 0x8000 -> ovf=1; prod=0x0000 without MUL_SAT_EN, 0x7FFF with it.
- Streaming: 4 consecutive valid pairs (1*1, 2*3, -2*4, 0*5 in Q8.8) -> out_valid high 4 consecutive cycles with prod 0x0100, 0x0600, 0xF800, 0x0000 in order.
- Reset: assert rst=0 asynchronously (mid-clock) with 2 pairs in flight -> out_valid, prod, ovf drop to 0 immediately. After release, no out_valid until 2 cycles after the next in_valid.
